// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus-protocol FSM states and acknowledge levels.
// Used by both the target and the master.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK
  } i2c_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with one history flop per line.
// Produces single-cycle SCL edge strobes and START/STOP condition strobes.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sr;
  logic [SYNC_STAGES-1:0] sda_sr;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  // Reset to the idle-bus level so leaving reset cannot fake a START.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_in};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_in};
      scl_d  <= scl_sr[SYNC_STAGES-1];
      sda_d  <= sda_sr[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sr[SYNC_STAGES-1];
  assign sda_s    = sda_sr[SYNC_STAGES-1];
  assign scl_rise =  scl_s & ~scl_d;
  assign scl_fall = ~scl_s &  scl_d;
  assign start    =  scl_s &  sda_d & ~sda_s;
  assign stop     =  scl_s & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with 7-bit address, oversampled bus, valid-pulse receive path and
// request/ack transmit fetch. SDA only changes on a detected SCL falling edge.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       rw,
  output logic       addr_hit,
  output logic       stop_det,
  output logic       busy
);

  i2c_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       byte_done_q, byte_done_d;
  logic       ack_q, ack_d;
  logic       sda_oe, sda_oe_d;
  logic       rw_d, busy_d;
  logic [7:0] rx_data_d;
  logic       rx_valid_d, tx_req_d, addr_hit_d, stop_det_d;

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl),
    .sda_in   (sda),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      byte_done_q <= 1'b0;
      ack_q       <= NACK;
      sda_oe      <= 1'b0;
      rw          <= 1'b0;
      busy        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_req      <= 1'b0;
      addr_hit    <= 1'b0;
      stop_det    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      byte_done_q <= byte_done_d;
      ack_q       <= ack_d;
      sda_oe      <= sda_oe_d;
      rw          <= rw_d;
      busy        <= busy_d;
      rx_data     <= rx_data_d;
      rx_valid    <= rx_valid_d;
      tx_req      <= tx_req_d;
      addr_hit    <= addr_hit_d;
      stop_det    <= stop_det_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    byte_done_d = byte_done_q;
    ack_d       = ack_q;
    sda_oe_d    = sda_oe;
    rw_d        = rw;
    busy_d      = busy;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    addr_hit_d  = 1'b0;
    stop_det_d  = 1'b0;

    if (stop) begin
      state_d    = IDLE;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else if (start) begin
      state_d     = ADDR;
      bit_cnt_d   = 3'd7;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;

        // byte_done marks the 8th rise so bit_cnt never wraps by decrement.
        ADDR, WR_BYTE: begin
          if (scl_rise) begin
            shreg_d = {shreg_q[6:0], sda_s};
            if (bit_cnt_q == 3'd0) byte_done_d = 1'b1;
            else                   bit_cnt_d   = bit_cnt_q - 3'd1;
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            if (state_q == ADDR) begin
              if (shreg_q[7:1] == SLAVE_ADDR) begin
                sda_oe_d   = 1'b1;
                rw_d       = shreg_q[0];
                addr_hit_d = 1'b1;
                busy_d     = 1'b1;
                state_d    = ADDR_ACK;
              end else begin
                state_d = IDLE;
              end
            end else begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
              sda_oe_d   = rx_ready;
              ack_d      = rx_ready ? ACK : NACK;
              state_d    = WR_ACK;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            if (!rw) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd7;
              state_d   = WR_BYTE;
            end else begin
              shreg_d   = tx_data;
              tx_req_d  = 1'b1;
              sda_oe_d  = ~tx_data[7];
              bit_cnt_d = 3'd7;
              state_d   = RD_BYTE;
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            if (ack_q == ACK) begin
              bit_cnt_d = 3'd7;
              state_d   = WR_BYTE;
            end else begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end

        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              shreg_d   = {shreg_q[6:0], 1'b0};
              sda_oe_d  = ~shreg_q[6];
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            ack_d = sda_s;
          end else if (scl_fall) begin
            if (ack_q == ACK) begin
              shreg_d   = tx_data;
              tx_req_d  = 1'b1;
              sda_oe_d  = ~tx_data[7];
              bit_cnt_d = 3'd7;
              state_d   = RD_BYTE;
            end else begin
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
              state_d  = IDLE;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged master drives the bus, received
// bytes are scoreboarded against the bytes written.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 80;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m;
  logic       m_oe;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic       rw;
  logic       addr_hit;
  logic       stop_det;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] obs_rx[$];
  logic [7:0] tx_src[$];
  int         rx_ptr = 0;
  int         tx_idx = 0;

  int tx_req_cnt = 0, addr_hit_cnt = 0, stop_cnt = 0, slave_low_cnt = 0, busy_cnt = 0;
  int b_tx, b_addr, b_stop, b_low, b_busy;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave #(
    .SLAVE_ADDR  (7'h42),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl_m),
    .sda      (sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rw       (rw),
    .addr_hit (addr_hit),
    .stop_det (stop_det),
    .busy     (busy)
  );

  // Monitor: records DUT output events and supplies the next transmit byte.
  always @(negedge clk) begin
    if (rx_valid) obs_rx.push_back(rx_data);
    if (tx_req) begin
      tx_req_cnt++;
      tx_idx++;
    end
    if (addr_hit) addr_hit_cnt++;
    if (stop_det) stop_cnt++;
    if (busy) busy_cnt++;
    if (sda === 1'b0 && !m_oe) slave_low_cnt++;
    tx_data = (tx_idx < tx_src.size()) ? tx_src[tx_idx] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_tx = tx_req_cnt; b_addr = addr_hit_cnt; b_stop = stop_cnt;
    b_low = slave_low_cnt; b_busy = busy_cnt;
  endtask

  task automatic drain_rx(input string tag);
    check({tag, "_rx_count"}, obs_rx.size() - rx_ptr, exp_rx.size());
    while (rx_ptr < obs_rx.size() && exp_rx.size() != 0) begin
      check({tag, "_rx_data"}, obs_rx[rx_ptr], exp_rx.pop_front());
      rx_ptr++;
    end
    rx_ptr = obs_rx.size();
    exp_rx.delete();
  endtask

  task automatic i2c_start();
    m_oe = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    m_oe = 1'b1; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_rstart();
    m_oe = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    m_oe = 1'b1; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    m_oe = 1'b0; #Q;
  endtask

  task automatic send_bit(input logic b);
    m_oe = ~b; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic b);
    m_oe = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    b = sda; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic mack);
    logic bv;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(bv);
      d[i] = bv;
    end
    send_bit(mack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    logic       bv;

    reset = 1'b0; scl_m = 1'b1; m_oe = 1'b0; rx_ready = 1'b1;
    #20;
    check("rst_busy", busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_addr_hit", addr_hit, 0);
    check("rst_stop_det", stop_det, 0);
    check("rst_rw", rw, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_sda", sda, 1);
    #20 reset = 1'b1;
    #40;

    // Write 0xA5, 0x3C to 0x42
    snap();
    exp_rx.push_back(8'hA5);
    exp_rx.push_back(8'h3C);
    i2c_start();
    send_byte(8'h84, ack); check("t1_addr_ack", ack, ACK);
    check("t1_busy", busy, 1);
    check("t1_rw", rw, 0);
    send_byte(8'hA5, ack); check("t1_d0_ack", ack, ACK);
    send_byte(8'h3C, ack); check("t1_d1_ack", ack, ACK);
    i2c_stop(); #100;
    check("t1_addr_hit", addr_hit_cnt - b_addr, 1);
    check("t1_stop_det", stop_cnt - b_stop, 1);
    check("t1_busy_end", busy, 0);
    drain_rx("t1");

    // Write to non-matching 0x43
    snap();
    i2c_start();
    send_byte(8'h86, ack); check("t2_addr_nack", ack, NACK);
    send_byte(8'h55, ack); check("t2_d0_nack", ack, NACK);
    i2c_stop(); #100;
    check("t2_sda_driven", slave_low_cnt - b_low, 0);
    check("t2_addr_hit", addr_hit_cnt - b_addr, 0);
    check("t2_busy", busy_cnt - b_busy, 0);
    check("t2_stop_det", stop_cnt - b_stop, 1);
    drain_rx("t2");

    // Read 0x81, 0x7E from 0x42; NACK the second byte
    snap();
    tx_src.push_back(8'h81);
    tx_src.push_back(8'h7E);
    #20;
    i2c_start();
    send_byte(8'h85, ack); check("t3_addr_ack", ack, ACK);
    check("t3_rw", rw, 1);
    recv_byte(rd, ACK);  check("t3_rd0", rd, 8'h81);
    recv_byte(rd, NACK); check("t3_rd1", rd, 8'h7E);
    #100;
    check("t3_busy_after_nack", busy, 0);
    check("t3_tx_req", tx_req_cnt - b_tx, 2);
    check("t3_slave_low", slave_low_cnt - b_low > 0, 1);
    i2c_stop(); #100;
    check("t3_stop_det", stop_cnt - b_stop, 1);

    // Write 0x10, repeated START, read back tx byte
    snap();
    exp_rx.push_back(8'h10);
    tx_src.push_back(8'h5A);
    #20;
    i2c_start();
    send_byte(8'h84, ack); check("t4_addr_ack", ack, ACK);
    send_byte(8'h10, ack); check("t4_d0_ack", ack, ACK);
    i2c_rstart();
    send_byte(8'h85, ack); check("t4_raddr_ack", ack, ACK);
    check("t4_addr_hit", addr_hit_cnt - b_addr, 2);
    check("t4_rw", rw, 1);
    check("t4_rx_data", rx_data, 8'h10);
    recv_byte(rd, NACK); check("t4_rd0", rd, 8'h5A);
    i2c_stop(); #100;
    drain_rx("t4");

    // rx_ready low: byte NACKed, following byte ignored
    snap();
    rx_ready = 1'b0;
    exp_rx.push_back(8'hFF);
    i2c_start();
    send_byte(8'h84, ack); check("t5_addr_ack", ack, ACK);
    send_byte(8'hFF, ack); check("t5_d0_nack", ack, NACK);
    #100;
    check("t5_busy", busy, 0);
    b_low = slave_low_cnt;
    send_byte(8'h33, ack); check("t5_d1_ignored", ack, NACK);
    check("t5_sda_idle", slave_low_cnt - b_low, 0);
    i2c_stop(); #100;
    drain_rx("t5");
    rx_ready = 1'b1;

    // Reset in the middle of a read of 0x00
    tx_src.push_back(8'h00);
    #20;
    i2c_start();
    send_byte(8'h85, ack); check("t6_addr_ack", ack, ACK);
    for (int i = 0; i < 3; i++) recv_bit(bv);
    check("t6_bit4_driven", sda, 0);
    reset = 1'b0;
    #1;
    check("t6_rst_sda", sda, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_rw", rw, 0);
    check("t6_rst_rx_data", rx_data, 0);
    check("t6_rst_tx_req", tx_req, 0);
    #19;
    reset = 1'b1;
    #40;
    snap();
    exp_rx.push_back(8'h99);
    i2c_start();
    send_byte(8'h84, ack); check("t6_post_addr_ack", ack, ACK);
    send_byte(8'h99, ack); check("t6_post_d0_ack", ack, ACK);
    i2c_stop(); #100;
    check("t6_post_addr_hit", addr_hit_cnt - b_addr, 1);
    check("t6_post_stop", stop_cnt - b_stop, 1);
    drain_rx("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (slave) responding to a 7-bit address on an open-drain SDA/SCL bus.
- Counterpart of the team's I2C master: used on-chip to emulate peripherals, and as a bench responder for master regression.
- Oversamples SCL/SDA with the system clock.
- Presents received bytes on a valid-pulse interface and fetches transmit bytes through a request/ack handshake.
- No clock stretching.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit address this target acknowledges.
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 16x the SCL frequency.
- reset  input  1  asynchronous, active-low reset.
- scl  input  1  bus clock from the master.
- sda  inout  1  bus data; driven 0 when sda_oe=1, else high-Z.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-cycle pulse; rx_data is new.
- rx_ready  input  1  sampled at byte end: 1 means ACK the byte, 0 means NACK it.
- tx_data  input  8  byte to return on a read; must be stable when tx_req rises.
- tx_req  output  1  one-cycle pulse; tx_data is latched this cycle. The user presents the next byte before the following tx_req.
- rw  output  1  R/W bit of the current transaction.
- addr_hit  output  1  one-cycle pulse on address match.
- stop_det  output  1  one-cycle pulse on a STOP condition.
- busy  output  1  high from address match until STOP, non-matching START, or NACK abort.

Behaviour:
- Reset (reset=0, async) forces all outputs to 0, state to IDLE, sda_oe to 0 (SDA released), shift register to 0 and bit_cnt to 0.
- Synchronization: SCL and SDA each pass SYNC_STAGES flops plus one history flop.
  - scl_rise / scl_fall are derived from the synced values.
  - start = synced SDA 1->0 while SCL=1; stop = synced SDA 0->1 while SCL=1.
  - Detection latency is SYNC_STAGES+1 cycles after the pin edge.
- Priority: stop > start > bit events, evaluated in every state.
  - stop: state to IDLE, release SDA, busy=0, pulse stop_det.
  - start (including repeated start): state to ADDR, bit_cnt=7, release SDA, busy=0.
- States:
  - IDLE: SDA released; ignores everything except start.
  - ADDR: shift SDA in MSB-first on each scl_rise.
    - After the 8th rise, on the next scl_fall compare bits[7:1] with SLAVE_ADDR.
    - Match: sda_oe=1 (ACK), rw=bit0, pulse addr_hit, busy=1, state to ADDR_ACK.
    - Mismatch: state to IDLE; no bus activity until the next start.
  - ADDR_ACK: on scl_fall:
    - rw=0: release SDA, bit_cnt=7, state to WR_BYTE.
    - rw=1: latch tx_data, pulse tx_req, drive bit7 (sda_oe = ~bit), state to RD_BYTE.
  - WR_BYTE: shift on scl_rise. On the scl_fall after the 8th bit:
    - rx_data <= byte and pulse rx_valid.
    - sda_oe = rx_ready; state to WR_ACK.
  - WR_ACK: on scl_fall, release SDA.
    - Byte was ACKed: state to WR_BYTE with bit_cnt=7.
    - Byte was NACKed: state to IDLE with busy=0.
  - RD_BYTE: on each scl_fall shift out the next bit; sda_oe=1 only for a 0 bit.
    - On the scl_fall ending bit0, release SDA and go to RD_ACK.
  - RD_ACK: sample SDA on scl_rise. On scl_fall:
    - ACK (0): latch tx_data, pulse tx_req, drive bit7, state to RD_BYTE.
    - NACK (1): release SDA, state to IDLE, busy=0.
- Bit counter: 3-bit, decrements per bit and wraps 0 to 7 only via explicit reload.
- SDA is changed only on detected scl_fall, giving at least SYNC_STAGES+1 clk of hold after the SCL falling edge.
- A general-call address (0x00) is not acknowledged unless SLAVE_ADDR=0.
- Pulse outputs never overlap the cycle of a start/stop-induced state change, except stop_det.
- Reset asserted mid-byte releases SDA immediately, with no glitch low.

Decomposition:
- Package i2c_pkg: state localparams (IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK) and ACK=1'b0 / NACK=1'b1 constants, shared with the master.
- Sub-module i2c_bus_sync: synchronizer, history flops and scl_rise / scl_fall / start / stop detection; reusable by the master for arbitration later.

Test Plan:
- Write to 0x42 with bytes 0xA5, 0x3C, then STOP, rx_ready=1 -> ACK on the address and both bytes; rx_valid pulses twice with rx_data 0xA5 then 0x3C; addr_hit=1 once; rw=0; stop_det pulse; busy back to 0.
- Address 0x43 write -> SDA never driven; no addr_hit or rx_valid; busy stays 0; stop_det still pulses.
- Read from 0x42 with tx_data 0x81 then 0x7E, master ACKs the first byte and NACKs the second -> SDA bits match 10000001 / 01111110; tx_req pulses twice; state IDLE after the NACK.
- Write 0x42 with byte 0x10, repeated START, read 0x42 -> rx_data=0x10; second addr_hit with rw=1; first read byte equals tx_data.
- rx_ready=0 on a write byte 0xFF -> rx_valid pulses; 9th-bit SDA reads 1 (NACK); further bytes are ignored until START.
- reset driven low during bit 4 of a read of 0x00 -> sda_oe=0 asynchronously; all outputs 0; after release, the next valid START/address is acknowledged normally.
